uart_rx_fifo_ctrl: RTL and testbench

//  Sequences the 16550 receive FIFO (uart_fifo instance) between the RX

---
 rtl/uart_rx_fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - 16550 receive FIFO sequencer
// Owns FCR state, occupancy count, FIFO strobes, RDA/timeout interrupts and LSR flags.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 5,
  parameter int TO_CHARS = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        fcr_we,
  input  logic [7:0]  fcr_dat,
  input  logic        rbr_re,
  input  logic        lsr_re,
  input  logic        rx_valid,
  input  logic [10:0] rx_dat,
  input  logic        char_tick,
  input  logic        fifo_all_error,
  output logic        fifo_push,
  output logic [10:0] fifo_push_dat,
  output logic        fifo_pop,
  output logic        fifo_clear,
  output logic [1:0]  trig_level,
  output logic        fifo_en,
  output logic        rda_irq,
  output logic        cto_irq,
  output logic        lsr_dr,
  output logic        lsr_oe,
  output logic        lsr_fifo_err
);

  localparam int TMR_W = (TO_CHARS > 1) ? $clog2(TO_CHARS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TOUT} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cap, thr;
  logic               en_d;
  logic [1:0]         trig_d;
  logic               drop;
  logic               rda_d;
  logic               unused_fcr;

  assign unused_fcr = ^fcr_dat[5:2];

  // Toggling the enable bit implicitly flushes the FIFO, as on a real 16550.
  assign fifo_clear    = fcr_we & (fcr_dat[1] | (fcr_dat[0] != fifo_en));
  assign cap           = fifo_en ? CNT_W'(DEPTH) : CNT_W'(1);
  assign fifo_pop      = rbr_re & (count_q != '0) & ~fifo_clear;
  assign fifo_push     = rx_valid & ((count_q < cap) | fifo_pop) & ~fifo_clear;
  assign drop          = rx_valid & ~fifo_clear & ~fifo_push;
  assign fifo_push_dat = rx_dat;
  assign lsr_fifo_err  = fifo_en & fifo_all_error;

  assign en_d   = fcr_we ? fcr_dat[0]   : fifo_en;
  assign trig_d = fcr_we ? fcr_dat[7:6] : trig_level;

  always_comb begin
    count_d = count_q;
    if (fifo_clear)
      count_d = '0;
    else if (fifo_push && !fifo_pop)
      count_d = count_q + CNT_W'(1);
    else if (fifo_pop && !fifo_push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    case (trig_d)
      2'b00:   thr = CNT_W'(1);
      2'b01:   thr = CNT_W'(4);
      2'b10:   thr = CNT_W'(8);
      default: thr = CNT_W'(14);
    endcase
  end

  assign rda_d = en_d ? (count_d >= thr) : (count_d != '0);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      fifo_en    <= 1'b0;
      trig_level <= 2'b00;
      count_q    <= '0;
      rda_irq    <= 1'b0;
      lsr_dr     <= 1'b0;
      lsr_oe     <= 1'b0;
    end else begin
      fifo_en    <= en_d;
      trig_level <= trig_d;
      count_q    <= count_d;
      rda_irq    <= rda_d;
      lsr_dr     <= (count_d != '0);
      if (drop)
        lsr_oe <= 1'b1;
      else if (lsr_re)
        lsr_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Timeout only runs in FIFO mode while characters sit unread.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (fifo_clear || !en_d || count_d == '0) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
          timer_d = '0;
        end
        S_ARMED: begin
          if (fifo_push || fifo_pop) begin
            timer_d = '0;
          end else if (char_tick) begin
            if (timer_q == TMR_W'(TO_CHARS - 1)) begin
              state_d = S_TOUT;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        S_TOUT: begin
          if (fifo_push || fifo_pop) begin
            state_d = S_ARMED;
            timer_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cto_irq = 1'b0;
    if (state_q == S_TOUT)
      cto_irq = 1'b1;
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - self-checking bench for uart_rx_fifo_ctrl
// Compares the DUT against an occupancy/idle-time model of the receive FIFO rules.
module tb_uart_rx_fifo_ctrl;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        fcr_we, rbr_re, lsr_re, rx_valid, char_tick, fifo_all_error;
  logic [7:0]  fcr_dat;
  logic [10:0] rx_dat;
  logic        fifo_push, fifo_pop, fifo_clear, fifo_en;
  logic        rda_irq, cto_irq, lsr_dr, lsr_oe, lsr_fifo_err;
  logic [10:0] fifo_push_dat;
  logic [1:0]  trig_level;

  int vectors = 0;
  int errors  = 0;

  bit       m_en, m_oe;
  bit [1:0] m_trig;
  int       m_cnt, m_idle;

  logic [14:0] obs_c, exp_c;
  logic [6:0]  obs_r, exp_r;

  uart_rx_fifo_ctrl dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .fcr_we(fcr_we), .fcr_dat(fcr_dat),
    .rbr_re(rbr_re), .lsr_re(lsr_re), .rx_valid(rx_valid), .rx_dat(rx_dat),
    .char_tick(char_tick), .fifo_all_error(fifo_all_error),
    .fifo_push(fifo_push), .fifo_push_dat(fifo_push_dat), .fifo_pop(fifo_pop),
    .fifo_clear(fifo_clear), .trig_level(trig_level), .fifo_en(fifo_en),
    .rda_irq(rda_irq), .cto_irq(cto_irq), .lsr_dr(lsr_dr), .lsr_oe(lsr_oe),
    .lsr_fifo_err(lsr_fifo_err)
  );

  always #5 clk_i = ~clk_i;

  function automatic int thr(input bit [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 8;
      default: return 14;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_oe = 0; m_trig = 0; m_cnt = 0; m_idle = 0;
  endtask

  task automatic idle_inputs();
    fcr_we = 0; fcr_dat = 0; rbr_re = 0; lsr_re = 0; rx_valid = 0;
    rx_dat = 0; char_tick = 0; fifo_all_error = 0;
  endtask

  // Called at posedge+1: drive one cycle, sample strobes at negedge, outputs at next posedge+1.
  task automatic apply(input bit we, input bit [7:0] fd, input bit rv, input bit [10:0] rd,
                       input bit rre, input bit lre, input bit tick, input bit ferr);
    bit clr, pop, push, drop;
    fcr_we = we; fcr_dat = fd; rx_valid = rv; rx_dat = rd;
    rbr_re = rre; lsr_re = lre; char_tick = tick; fifo_all_error = ferr;
    @(negedge clk_i);
    obs_c = {fifo_push, fifo_pop, fifo_clear, lsr_fifo_err, fifo_push_dat};
    clr  = we && (fd[1] || (fd[0] != m_en));
    pop  = !clr && rre && (m_cnt > 0);
    push = !clr && rv && ((m_cnt < (m_en ? 16 : 1)) || pop);
    drop = !clr && rv && !push;
    exp_c = {push, pop, clr, m_en & ferr, rd};
    if (we) begin m_en = fd[0]; m_trig = fd[7:6]; end
    if (clr) m_cnt = 0;
    else     m_cnt = m_cnt + int'(push) - int'(pop);
    if (drop)     m_oe = 1;
    else if (lre) m_oe = 0;
    if (clr || m_cnt == 0 || !m_en || push || pop) m_idle = 0;
    else if (tick && m_idle < 4)                   m_idle++;
    exp_r = {(m_en ? (m_cnt >= thr(m_trig)) : (m_cnt != 0)),
             (m_en && m_cnt > 0 && m_idle >= 4), (m_cnt != 0), m_oe, m_en, m_trig};
    @(posedge clk_i); #1;
    obs_r = {rda_irq, cto_irq, lsr_dr, lsr_oe, fifo_en, trig_level};
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst_i = 0;
    model_reset();
    #12;
    vectors++;
    if ({fifo_push, fifo_pop, fifo_clear, fifo_en, trig_level, rda_irq, cto_irq,
         lsr_dr, lsr_oe, lsr_fifo_err, fifo_push_dat} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs, required all 0");
    end
    @(posedge clk_i); #1;
    nrst_i = 1;
  endtask

  task automatic test_trigger14();
    apply(1, 8'hC1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs_r !== exp_r) begin errors++; $display("FAIL trig14_fcr got %b required %b", obs_r, exp_r); end
    for (int i = 0; i < 14; i++) begin
      apply(0, 0, 1, 11'($urandom), 0, 0, 0, 1'($urandom));
      vectors++;
      if (obs_c !== exp_c) begin errors++; $display("FAIL trig14_strobe%0d got %h required %h", i, obs_c, exp_c); end
      vectors++;
      if (rda_irq !== (i == 13)) begin errors++; $display("FAIL trig14_rda%0d got %b required %b", i, rda_irq, i == 13); end
    end
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    vectors++;
    if (rda_irq !== 1'b0 || obs_r !== exp_r) begin errors++; $display("FAIL trig14_read got %b required %b", obs_r, exp_r); end
  endtask

  task automatic test_timeout();
    apply(1, 8'h43, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 11'h0A5, 0, 0, 0, 0);
    apply(0, 0, 1, 11'h05A, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      vectors++;
      if (cto_irq !== (k == 3) || obs_r !== exp_r) begin
        errors++; $display("FAIL timeout_tick%0d got %b required %b", k, obs_r, exp_r);
      end
    end
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    vectors++;
    if (cto_irq !== 1'b0 || obs_r !== exp_r) begin errors++; $display("FAIL timeout_read got %b required %b", obs_r, exp_r); end
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (cto_irq !== 1'b1 || obs_r !== exp_r) begin errors++; $display("FAIL timeout_rearm got %b required %b", obs_r, exp_r); end
  endtask

  task automatic test_overrun();
    apply(1, 8'h03, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      apply(0, 0, 1, 11'($urandom), 0, 0, 0, 0);
      vectors++;
      if (obs_c[14] !== (i < 16) || obs_c !== exp_c) begin
        errors++; $display("FAIL overrun_push%0d got %h required %h", i, obs_c, exp_c);
      end
    end
    vectors++;
    if (lsr_oe !== 1'b1 || lsr_dr !== 1'b1 || obs_r !== exp_r) begin errors++; $display("FAIL overrun_flag got %b required %b", obs_r, exp_r); end
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (lsr_oe !== 1'b0) begin errors++; $display("FAIL overrun_lsr_read got %b required 0", lsr_oe); end
    apply(0, 0, 1, 11'h1FF, 1, 0, 0, 0);
    vectors++;
    if (obs_c[14:12] !== 3'b110 || obs_c !== exp_c || obs_r !== exp_r) begin
      errors++; $display("FAIL overrun_pushpop got %h/%b required %h/%b", obs_c, obs_r, exp_c, exp_r);
    end
  endtask

  task automatic test_holding_mode();
    apply(1, 8'h00, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 11'h041, 0, 0, 0, 1);
    apply(0, 0, 1, 11'h042, 0, 0, 0, 1);
    vectors++;
    if (obs_c[14] !== 1'b0 || obs_c !== exp_c) begin errors++; $display("FAIL holding_drop got %h required %h", obs_c, exp_c); end
    for (int k = 0; k < 6; k++) apply(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if ({rda_irq, cto_irq, lsr_dr, lsr_oe} !== 4'b1011 || obs_r !== exp_r) begin
      errors++; $display("FAIL holding_flags got %b required %b", obs_r, exp_r);
    end
  endtask

  task automatic test_clear_priority();
    apply(1, 8'h01, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 11'($urandom), 0, 0, 0, 0);
    apply(1, 8'h03, 1, 11'h3C3, 1, 0, 0, 0);
    vectors++;
    if (obs_c[14:12] !== 3'b001 || obs_c !== exp_c) begin errors++; $display("FAIL clear_strobes got %h required %h", obs_c, exp_c); end
    vectors++;
    if ({rda_irq, cto_irq, lsr_dr} !== 3'b000 || obs_r !== exp_r) begin
      errors++; $display("FAIL clear_flags got %b required %b", obs_r, exp_r);
    end
  endtask

  task automatic test_async_reset();
    apply(1, 8'h81, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) apply(0, 0, 1, 11'($urandom), 0, 0, 0, 0);
    #2;
    idle_inputs();
    nrst_i = 0;
    #1;
    vectors++;
    if ({fifo_push, fifo_pop, fifo_clear, fifo_en, trig_level, rda_irq, cto_irq,
         lsr_dr, lsr_oe, lsr_fifo_err} !== 11'd0) begin
      errors++; $display("FAIL async_reset outputs not cleared before next edge");
    end
    @(posedge clk_i); #3;
    nrst_i = 1;
    model_reset();
    @(posedge clk_i); #1;
    apply(1, 8'h41, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 11'($urandom), 0, 0, 0, 0);
      vectors++;
      if (obs_c !== exp_c || obs_r !== exp_r) begin
        errors++; $display("FAIL async_resume%0d got %h/%b required %h/%b", i, obs_c, obs_r, exp_c, exp_r);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit we;
      bit [7:0] fd;
      int rd_pct;
      rd_pct = (n < 300) ? 15 : 60;
      we = ($urandom_range(0, 39) == 0);
      fd = 8'($urandom);
      fd[0] = ($urandom_range(0, 9) < 8);
      fd[1] = ($urandom_range(0, 3) == 0);
      apply(we, fd, ($urandom_range(0, 99) < 50), 11'($urandom),
            ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < 35), 1'($urandom));
      vectors++;
      if (obs_c !== exp_c) begin errors++; $display("FAIL random_strobes%0d got %h required %h", n, obs_c, exp_c); end
      vectors++;
      if (obs_r !== exp_r) begin errors++; $display("FAIL random_regs%0d got %b required %b", n, obs_r, exp_r); end
    end
  endtask

  initial begin
    test_reset();
    test_trigger14();
    test_timeout();
    test_overrun();
    test_holding_mode();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
